// File: rtl/pll_seq_pkg.sv
// Shared state encoding, count width and counter-width helper for the PLL reset sequencer.
package pll_seq_pkg;

  localparam int COUNT_W = 8;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAULT     = 3'd4;

  typedef enum logic [2:0] {
    PLL_RST   = ST_PLL_RST,
    WAIT_LOCK = ST_WAIT_LOCK,
    STABLE    = ST_STABLE,
    RUN       = ST_RUN,
    FAULT     = ST_FAULT
  } pll_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up/recovery sequencer: pulses PLL reset, qualifies lock, releases sys reset.
// Define PLL_SEQ_LOCK_LOSS_CNT_EN to build the saturating lock-loss counter.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               i_refclk,
  input  logic               i_rst,
  input  logic               i_pll_locked,
  input  logic               i_relock_req,
  output logic               o_pll_rst,
  output logic               o_sys_rst,
  output logic               o_clk_ready,
  output logic               o_fault,
  output logic [COUNT_W-1:0] o_retry_cnt,
  output logic [COUNT_W-1:0] o_lock_loss_cnt
);

  localparam int RST_W = cnt_width(RST_PULSE_CYCLES);
  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_PULSE_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [COUNT_W-1:0] RETRY_MAX = COUNT_W'(MAX_RETRIES);

  logic               w_locked_s;
  pll_state_e         r_state;
  pll_state_e         w_state_next;
  logic [RST_W-1:0]   r_rst_cnt;
  logic [RST_W-1:0]   w_rst_cnt_next;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [TMO_W-1:0]   w_tmo_cnt_next;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic               w_tmo_hit;
  logic [STB_W-1:0]   r_stb_cnt;
  logic [STB_W-1:0]   w_stb_cnt_next;
  logic [COUNT_W-1:0] r_retry;
  logic [COUNT_W-1:0] w_retry_next;
  logic               w_timeout;

  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_clk_ready;
  logic               r_fault;
  logic [COUNT_W-1:0] r_retry_out;

  sync_2ff u_lock_sync (
    .i_clk (i_refclk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_locked_s)
  );

  // The timeout counter saturates so a lock seen on the last cycle cannot wrap it
  // and buy the attempt a fresh timeout window.
  assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
  assign w_tmo_inc = w_tmo_hit ? r_tmo_cnt : r_tmo_cnt + 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_rst_cnt_next = '0;
    w_tmo_cnt_next = r_tmo_cnt;
    w_stb_cnt_next = r_stb_cnt;
    w_retry_next   = r_retry;
    w_timeout      = 1'b0;
    case (r_state)
      PLL_RST: begin
        if (r_rst_cnt == RST_LAST) begin
          w_state_next   = WAIT_LOCK;
          w_tmo_cnt_next = '0;
        end else begin
          w_rst_cnt_next = r_rst_cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        w_tmo_cnt_next = w_tmo_inc;
        if (w_locked_s) begin
          w_state_next   = STABLE;
          w_stb_cnt_next = '0;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
        end
      end
      STABLE: begin
        w_tmo_cnt_next = w_tmo_inc;
        if (w_tmo_hit) begin
          w_timeout = 1'b1;
        end else if (!w_locked_s) begin
          w_state_next = WAIT_LOCK;
        end else if (r_stb_cnt == STB_LAST) begin
          w_state_next = RUN;
        end else begin
          w_stb_cnt_next = r_stb_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!w_locked_s || i_relock_req) begin
          w_state_next = PLL_RST;
          w_retry_next = '0;
        end
      end
      FAULT: begin
        if (i_relock_req) begin
          w_state_next = PLL_RST;
          w_retry_next = '0;
        end
      end
      default: w_state_next = PLL_RST;
    endcase

    if (w_timeout) begin
      if (r_retry < RETRY_MAX) begin
        w_retry_next = r_retry + 1'b1;
        w_state_next = PLL_RST;
      end else begin
        w_state_next = FAULT;
      end
    end
  end

  // Outputs are decoded from the current state, so they follow it by one cycle.
  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= PLL_RST;
      r_rst_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_stb_cnt   <= '0;
      r_retry     <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_clk_ready <= 1'b0;
      r_fault     <= 1'b0;
      r_retry_out <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rst_cnt   <= w_rst_cnt_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_stb_cnt   <= w_stb_cnt_next;
      r_retry     <= w_retry_next;
      r_pll_rst   <= (r_state == PLL_RST);
      r_sys_rst   <= (r_state != RUN);
      r_clk_ready <= (r_state == RUN);
      r_fault     <= (r_state == FAULT);
      r_retry_out <= r_retry;
    end
  end

  assign o_pll_rst   = r_pll_rst;
  assign o_sys_rst   = r_sys_rst;
  assign o_clk_ready = r_clk_ready;
  assign o_fault     = r_fault;
  assign o_retry_cnt = r_retry_out;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  logic               w_lock_loss;
  logic [COUNT_W-1:0] r_lock_loss_cnt;
  logic [COUNT_W-1:0] r_lock_loss_out;

  // A relock request on the same cycle as a drop still counts as a loss.
  assign w_lock_loss = (r_state == RUN) && !w_locked_s;

  always_ff @(posedge i_refclk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_loss_cnt <= '0;
      r_lock_loss_out <= '0;
    end else begin
      if (w_lock_loss && (r_lock_loss_cnt != {COUNT_W{1'b1}})) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
      end
      r_lock_loss_out <= r_lock_loss_cnt;
    end
  end

  assign o_lock_loss_cnt = r_lock_loss_out;
`else
  assign o_lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: a timestamp-based reference model queues every expected output change,
// a negedge monitor pops and compares whenever the DUT outputs change.
module tb_pll_reset_sequencer;

  localparam int P  = 4;
  localparam int S  = 8;
  localparam int T  = 32;
  localparam int MR = 2;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
  localparam bit LLC_EN = 1'b1;
`else
  localparam bit LLC_EN = 1'b0;
`endif
  localparam int MP_RST    = 0;
  localparam int MP_WAIT   = 1;
  localparam int MP_STABLE = 2;
  localparam int MP_RUN    = 3;
  localparam int MP_FAULT  = 4;
  localparam logic [19:0] RESET_TUPLE = {4'b1100, 8'd0, 8'd0};

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst;
  logic       clk_ready;
  logic       fault;
  logic [7:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES    (P),
    .LOCK_STABLE_CYCLES  (S),
    .LOCK_TIMEOUT_CYCLES (T),
    .MAX_RETRIES         (MR)
  ) dut (
    .i_refclk        (clk),
    .i_rst           (rst),
    .i_pll_locked    (pll_locked),
    .i_relock_req    (relock_req),
    .o_pll_rst       (pll_rst),
    .o_sys_rst       (sys_rst),
    .o_clk_ready     (clk_ready),
    .o_fault         (fault),
    .o_retry_cnt     (retry_cnt),
    .o_lock_loss_cnt (lock_loss_cnt)
  );

  typedef struct {
    int          cyc;
    logic [19:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: phase plus timestamps of when it (and the current attempt) began.
  int          m_phase;
  int          m_t0;
  int          m_att_t0;
  int          m_retry;
  int          m_llc;
  bit          m_hist[$];
  logic [19:0] m_last;
  bit          m_have_last = 1'b0;

  function automatic logic [19:0] dut_tuple();
    return {pll_rst, sys_rst, clk_ready, fault, retry_cnt, lock_loss_cnt};
  endfunction

  task automatic push_exp(input logic [19:0] v);
    exp_t e;
    if (!m_have_last || v !== m_last) begin
      e.cyc = cyc;
      e.val = v;
      exp_q.push_back(e);
      m_last      = v;
      m_have_last = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_phase  = MP_RST;
    m_t0     = cyc;
    m_att_t0 = cyc;
    m_retry  = 0;
    m_llc    = 0;
    m_hist.delete();
  endtask

  task automatic model_enter_rst();
    m_phase = MP_RST;
    m_t0    = cyc;
  endtask

  task automatic model_timeout();
    if (m_retry < MR) begin
      m_retry++;
      model_enter_rst();
    end else begin
      m_phase = MP_FAULT;
    end
  endtask

  task automatic model_edge();
    bit ls;
    bit tmo_ready;
    int n;
    n = cyc;
    push_exp({m_phase == MP_RST, m_phase != MP_RUN, m_phase == MP_RUN, m_phase == MP_FAULT,
              8'(m_retry), 8'(m_llc)});
    if (rst) begin
      model_reset();
      return;
    end
    // locked as seen by the sequencer is the input from two edges earlier
    m_hist.push_back(pll_locked);
    if (m_hist.size() > 3) void'(m_hist.pop_front());
    ls = (m_hist.size() == 3) ? m_hist[0] : 1'b0;
    tmo_ready = (n - m_att_t0) >= T;
    case (m_phase)
      MP_RST: begin
        if (n - m_t0 == P) begin
          m_phase  = MP_WAIT;
          m_att_t0 = n;
        end
      end
      MP_WAIT: begin
        if (ls) begin
          m_phase = MP_STABLE;
          m_t0    = n;
        end else if (tmo_ready) begin
          model_timeout();
        end
      end
      MP_STABLE: begin
        if (tmo_ready) model_timeout();
        else if (!ls) m_phase = MP_WAIT;
        else if (n - m_t0 == S) m_phase = MP_RUN;
      end
      MP_RUN: begin
        if (!ls || relock_req) begin
          if (!ls && LLC_EN && m_llc < 255) m_llc++;
          m_retry = 0;
          model_enter_rst();
        end
      end
      MP_FAULT: begin
        if (relock_req) begin
          m_retry = 0;
          model_enter_rst();
        end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #2;
  endtask

  task automatic hold(input logic lk, input int n);
    pll_locked = lk;
    repeat (n) tick();
  endtask

  task automatic relock();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
  endtask

  // Monitor: every change of the DUT output tuple is one transaction.
  logic [19:0] mon_last;
  bit          mon_seen = 1'b0;

  always @(negedge clk) begin : monitor
    logic [19:0] cur;
    exp_t        e;
    cur = dut_tuple();
    if (!mon_seen || cur !== mon_last) begin
      mon_seen = 1'b1;
      mon_last = cur;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cycle %0d got %05h, nothing expected", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e.val !== cur || e.cyc != cyc) begin
          errors++;
          $display("FAIL output_change: got %05h at cycle %0d, expected %05h at cycle %0d",
                   cur, cyc, e.val, e.cyc);
        end else begin
          $display("txn cycle %0d outputs %05h ok", cyc, cur);
        end
      end
    end
  end

  initial begin
    logic lk;
    int   len;
    int   guard;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // nominal bring-up
    hold(1'b0, 10);
    hold(1'b1, 50);
    checks++;
    if (sys_rst !== 1'b0 || clk_ready !== 1'b1 || retry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nominal_run: sys_rst=%b clk_ready=%b retry=%0d, need 0 1 0",
               sys_rst, clk_ready, retry_cnt);
    end

    // short lock losses while running
    for (int k = 0; k < 4; k++) begin
      hold(1'b0, $urandom_range(1, 3));
      hold(1'b1, 40);
    end

    // relock from RUN, then a relock during WAIT_LOCK that must be ignored
    relock();
    hold(1'b1, 40);
    hold(1'b0, 9);
    relock();
    hold(1'b0, 2);
    hold(1'b1, 40);

    // stuck unlocked: retries exhaust into FAULT
    hold(1'b0, (MR + 1) * (P + T) + 40);
    checks++;
    if (fault !== 1'b1 || pll_rst !== 1'b0 || sys_rst !== 1'b1 || retry_cnt !== 8'(MR)) begin
      errors++;
      $display("FAIL fault_hold: fault=%b pll_rst=%b sys_rst=%b retry=%0d, need 1 0 1 %0d",
               fault, pll_rst, sys_rst, retry_cnt, MR);
    end

    pll_locked = 1'b1;
    relock();
    hold(1'b1, 40);

    // lock chatter every 5 cycles never qualifies
    for (int i = 0; i < 150; i++) begin
      pll_locked = ((i / 5) % 2) == 0;
      tick();
    end
    pll_locked = 1'b1;
    relock();
    hold(1'b1, 40);

    // random lock segments with sporadic relock requests
    for (int seg = 0; seg < 120; seg++) begin
      lk  = ($urandom_range(0, 3) != 0);
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        relock_req = ($urandom_range(0, 39) == 0);
        pll_locked = lk;
        tick();
      end
    end
    relock_req = 1'b0;
    pll_locked = 1'b1;
    relock();
    hold(1'b1, 40);

    // 300 lock losses from RUN
    for (int k = 0; k < 300; k++) begin
      hold(1'b0, 1);
      hold(1'b1, 30);
    end
    checks++;
    if (lock_loss_cnt !== (LLC_EN ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL lock_loss_sat: got %0d, need %0d", lock_loss_cnt, LLC_EN ? 255 : 0);
    end

    // asynchronous reset in the middle of STABLE
    hold(1'b0, 1);
    pll_locked = 1'b1;
    guard = 0;
    while (m_phase != MP_STABLE && guard < 50) begin
      tick();
      guard++;
    end
    checks++;
    if (m_phase != MP_STABLE) begin
      errors++;
      $display("FAIL stable_wait: phase %0d after %0d cycles, need STABLE", m_phase, guard);
    end
    hold(1'b1, 2);
    rst = 1'b1;
    model_reset();
    push_exp(RESET_TUPLE);
    #1;
    checks++;
    if (dut_tuple() !== RESET_TUPLE) begin
      errors++;
      $display("FAIL async_reset: got %05h, need %05h", dut_tuple(), RESET_TUPLE);
    end
    hold(1'b1, 3);
    rst = 1'b0;
    hold(1'b1, 40);

    hold(1'b1, 5);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected changes never seen, need 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controls PLL bring-up and recovery. Runs on the PLL reference clock and drives the PLL reset pin. It qualifies the PLL locked output and releases a system reset for downstream clock domains only after lock has been stable. It handles lock timeout with a bounded number of retries, lock loss during operation, and a software-requested relock.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt (min 1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release (min 1)
LOCK_TIMEOUT_CYCLES, 65536, max refclk cycles from pll_rst release to qualified lock per attempt
MAX_RETRIES, 3, extra attempts after the first timeout before FAULT (0..255)

Ports:
refclk  in  1  reference clock; sequencer clock
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
relock_req  in  1  single-cycle request to re-run the full sequence
pll_rst  out  1  PLL reset, active-high
sys_rst  out  1  downstream reset, active-high; released synchronously to refclk
clk_ready  out  1  high only in RUN
fault  out  1  high only in FAULT
retry_cnt  out  8  timeouts in the current bring-up
lock_loss_cnt  out  8  saturating count of lock losses in RUN (optional feature)

Behaviour:
- Interface: one clock (refclk); reset (rst) is asynchronous and active-high.
- Reset values: pll_rst=1, sys_rst=1, clk_ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0; state=PLL_RST, all counters 0.
- pll_locked passes through a 2-flop synchroniser, giving locked_s with 2 cycles of latency. The FSM uses only locked_s.
- All outputs are registered and decoded from the state; they change the cycle after the state transition.
- PLL_RST:
  - pll_rst=1.
  - Counts RST_PULSE_CYCLES cycles, then enters WAIT_LOCK.
  - Clears the timeout counter on exit.
- WAIT_LOCK:
  - pll_rst=0; the timeout counter increments.
  - locked_s=1 goes to STABLE with the stable counter at 0.
  - Timeout counter reaching LOCK_TIMEOUT_CYCLES-1 with no lock is a timeout. If retry_cnt<MAX_RETRIES: retry_cnt++, go to PLL_RST. Otherwise go to FAULT.
- STABLE:
  - The timeout counter keeps running, and the stable counter increments while locked_s=1.
  - locked_s=0 returns to WAIT_LOCK without clearing the timeout counter, so lock chatter cannot loop forever.
  - The stable counter reaching LOCK_STABLE_CYCLES-1 goes to RUN.
  - Timeout checking applies here exactly as in WAIT_LOCK; timeout takes priority over reaching RUN on the same cycle.
- RUN:
  - sys_rst=0, clk_ready=1, retry_cnt holds its final value.
  - locked_s=0 goes to PLL_RST: sys_rst reasserts the next cycle, retry_cnt clears, lock_loss_cnt++ (saturating at 255).
- FAULT:
  - pll_rst=0, sys_rst=1, fault=1.
  - Stays in FAULT until relock_req or rst.
- relock_req:
  - Honoured only in RUN or FAULT: go to PLL_RST, clear retry_cnt and fault. A relock_req does not count as a lock loss.
  - Ignored in PLL_RST, WAIT_LOCK and STABLE.
  - In RUN, if relock_req and locked_s=0 occur on the same cycle, the event is treated as a lock loss (counter increments).
- rst mid-sequence forces reset values immediately, asynchronously. lock_loss_cnt is also cleared.
- Counter widths are $clog2 of the parameter, minimum 1 bit.

Optional Feature:
- Macro: PLL_SEQ_LOCK_LOSS_CNT_EN.
- Defined: lock_loss_cnt is implemented as above.
- Undefined: the counter is not built and lock_loss_cnt is tied to 8'd0. All other behaviour is identical.

Decomposition:
- Package pll_seq_pkg: state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT), the 8-bit count width constant, and a width helper function.
- One sub-module, sync_2ff: 2-flop synchroniser with async active-high reset to 0. It is reused elsewhere for CDC of single bits.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2):
1. Nominal: release rst; pll_locked=1 from cycle 10 -> pll_rst high 4 cycles; sys_rst falls exactly 2+8 cycles after locked entry into WAIT_LOCK; clk_ready=1; retry_cnt=0.
2. Timeout retries: pll_locked stuck 0 -> three PLL_RST pulses of 4 cycles spaced by 32-cycle waits; retry_cnt goes 0,1,2; then fault=1, sys_rst=1, pll_rst=0 held indefinitely.
3. Chatter: pll_locked toggles every 5 cycles -> STABLE never completes; timeout fires 32 cycles after pll_rst release; retry_cnt increments.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> within 3 cycles sys_rst=1, clk_ready=0, pll_rst pulses 4 cycles, lock_loss_cnt=1; relock -> RUN again.
5. relock_req: from FAULT and from RUN -> PLL_RST, fault=0, retry_cnt=0, lock_loss_cnt unchanged. Same request during WAIT_LOCK -> no effect.
6. Async rst asserted mid-STABLE -> outputs take reset values in the same cycle without a clock edge. With the macro undefined, 300 lock losses -> lock_loss_cnt=0; with it defined -> 255 (saturated).
